// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//   Writeback queue between a result producer and a single register-file write
//   port. Requests are held in a DEPTH-entry FIFO and retired in order whenever
//   the write port is free (rf_stall low). Writes to x0 are accepted and
//   dropped. The head entry is presented combinationally to the register file.
//
//   Optional feature: define WBQ_BYPASS_EN to enable two lookup ports that
//   return the youngest queued value for a register. Without it the bypass
//   outputs are tied low.
//
// Parameters
//   XLEN   register data width
//   DEPTH  queue entries, power of two, 2..16
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   wb_valid/wb_ready               producer handshake
//   wb_index, wb_data               destination register and value
//   rf_stall                        register-file write port busy this cycle
//   RegWEn/RegWriteIndex/Data       register-file write port
//   count                           occupied entries
//   byp_idx1/2                      bypass lookup indices
//   byp_hit1/2, byp_data1/2         bypass results
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_index,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     rf_stall,
    output logic                     RegWEn,
    output logic [4:0]               RegWriteIndex,
    output logic [XLEN-1:0]          RegWriteData,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [4:0]               byp_idx1,
    input  logic [4:0]               byp_idx2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [XLEN-1:0]          byp_data1,
    output logic [XLEN-1:0]          byp_data2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      idx_mem  [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty && !rf_stall;

    // A full queue still accepts when the head retires on the same edge.
    assign wb_ready = !full || pop;
    assign push     = wb_valid && wb_ready && (wb_index != 5'd0);

    assign RegWEn        = pop;
    assign RegWriteIndex = empty ? 5'd0 : idx_mem[rd_ptr];
    assign RegWriteData  = empty ? '0   : data_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem[wr_ptr]  <= wb_index;
            data_mem[wr_ptr] <= wb_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [PW-1:0] slot;

    // Scan oldest to youngest so the last match wins. The head being popped
    // this cycle is still inside count, so it remains visible.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (byp_idx1 != 5'd0 && idx_mem[slot] == byp_idx1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = data_mem[slot];
                end
                if (byp_idx2 != 5'd0 && idx_mem[slot] == byp_idx2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = data_mem[slot];
                end
            end
        end
    end
`else
    logic byp_unused;
    assign byp_unused = ^{byp_idx1, byp_idx2};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule
